mem_wb_lsu_stage: RTL and testbench
===================================

// Module: mem_wb_lsu_stage
// PURPOSE
//  Parametrised memory/writeback stage. It generalises the fixed 32-bit MemWB stage with:
//  - a ready/valid input from execute;
//  - a load-response wait FSM with timeout;
//  - byte-lane alignment of load data;
//  - error reporting;
//  - a retired-write history shift register.
//  Sits between execute and the register file and drives its single write port.
// PARAMETERS
//  XLEN        32  datapath/register width (>=32)
//  REGW        8   register index width
//  HIST_DEPTH  4   retired-write history entries (>=1)
//  TIMEOUT     15  max cycles in WAIT_MEM before abort (>=1)
// PORTS
//  clk            in   1            clock; single clock domain
//  reset          in   1            one clock; reset is asynchronous and active-low
//  in_valid       in   1            execute presents an instruction
//  in_ready       out  1            stage can accept
//  in_wb_op       in   3            wb_op_t: WNONE=0 ALU=1 MEM=2 PC2=3 PC4=4
//  in_funct3      in   3            load size/sign
//  in_rd          in   REGW         destination register
//  in_pc          in   XLEN         instruction pc
//  in_alu_result  in   XLEN         ALU result
//  in_addr_lo     in   2            load byte offset
//  mem_rsp_valid  in   1            load data valid
//  mem_rsp_data   in   32           aligned word from memory
//  mem_rsp_err    in   1            bus error with response
//  regs_write_out out  1            register-file write strobe
//  regs_wr_id_out out  REGW         write index
//  regs_data_out  out  XLEN         write data
//  err_out        out  1            1-cycle error pulse
//  busy_out       out  1            FSM in WAIT_MEM
//  hist_out       out  HIST_DEPTH*(REGW+1)  {valid,rd} per entry, entry 0 newest
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, all outputs 0 except in_ready=1, history cleared, counter 0.
//  Accept = in_valid & in_ready; in_ready = (state==IDLE).
//  IDLE, accept with op ALU/PC2/PC4:
//   - value = alu_result / pc+2 / pc+4, truncated to XLEN;
//   - regs_write_out=1 next cycle with captured rd; stays IDLE (throughput 1/cycle).
//  IDLE, accept with op WNONE: no write; hist entry has valid=0.
//  IDLE, accept with op MEM: capture rd/funct3/addr_lo; go to WAIT_MEM, counter=0.
//  WAIT_MEM:
//   - count each cycle; on mem_rsp_valid, extract and write on the next cycle, return to IDLE;
//   - in_ready is 1 again in that write cycle.
//   - Load latency: response in cycle N, write in cycle N+1.
//  Load extraction, shift = addr_lo*8:
//   - funct3 0 LB: sign-extend byte;   4 LBU: zero-extend byte;
//   - funct3 1 LH: sign-extend half;   5 LHU: zero-extend half; 2 LW: sign-extend word.
//  Misaligned (LH/LHU with addr_lo[0]=1, LW with addr_lo!=0), illegal funct3, or mem_rsp_err:
//   - no write; err_out pulse in the write cycle; return to IDLE.
//  Timeout: counter reaches TIMEOUT with no response:
//   - err_out pulse, IDLE, no write; a later stray response is ignored.
//  mem_rsp_valid while IDLE: ignored, err_out pulse.
//  rd==0: regs_write_out forced 0 (data still driven); err/history unaffected.
//  regs_write_out / err_out are single-cycle pulses.
//  History: shifts every clock; entry0 <= {write_strobe_this_cycle, rd}; drops the oldest entry.
//  Reset mid-WAIT_MEM: aborts to IDLE; a pending response is discarded.
// CONFIGURATION
//  MEMWB_BYPASS_EN defined: adds outputs
//   - byp_valid_out (1), byp_rd_out (REGW), byp_data_out (XLEN);
//   - these carry the about-to-be-written value combinationally one cycle early, same cycle as the response/accept, for execute forwarding.
//  Not defined: ports absent, no extra logic.
// STRUCTURE
//  Package mem_wb_lsu_pkg:
//   - wb_op_t enum; funct3 constants LB/LH/LW/LBU/LHU;
//   - fsm_t {IDLE, WAIT_MEM}; hist_entry_t struct {valid, rd}.
//  Sub-module load_align_ext:
//   - combinational; inputs data, addr_lo, funct3; outputs XLEN value and misalign/illegal flag.
//   - Unit-tested alone.
// TESTING
//  1. ALU op, rd=5, alu=0x1234 -> next cycle write=1, id=5, data=0x1234; in_ready stays 1.
//  2. MEM LB, addr_lo=2, rsp 3 cycles later with data=0x00800000 -> write cycle N+1, data=0xFFFFFF80.
//  3. LHU, addr_lo=1 -> err_out pulse, no write; back to IDLE.
//  4. MEM with no response, TIMEOUT=15 -> err_out after 15 WAIT cycles; a late rsp gives no write.
//  5. PC4 with rd=0, pc=0x100 -> write=0, data=0x104; hist entry0.valid=0.
//  6. Reset asserted during WAIT_MEM -> outputs 0 async, in_ready=1; rsp next cycle is ignored.

Source files
------------

// File: rtl/mem_wb_lsu_pkg.sv
// Package mem_wb_lsu_pkg
//   Shared types for the memory/writeback stage:
//   - wb_op_t   : writeback source selector presented by execute
//   - F3_*      : load size/sign encodings on funct3
//   - fsm_t     : stage state (IDLE / WAIT_MEM)
//   - hist_entry_t : layout of one retired-write history entry
//                    ({valid, rd}) for the default 8-bit register index
package mem_wb_lsu_pkg;

  typedef enum logic [2:0] {
    WNONE = 3'd0,
    ALU   = 3'd1,
    MEM   = 3'd2,
    PC2   = 3'd3,
    PC4   = 3'd4
  } wb_op_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } fsm_t;

  localparam int HIST_RD_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [HIST_RD_W-1:0] rd;
  } hist_entry_t;

endpackage

// File: rtl/load_align_ext.sv
// Module load_align_ext
//   Combinational byte-lane alignment and sign/zero extension of a load
//   response word.
//   Ports:
//     data_i     in  32    word returned by memory
//     addr_lo_i  in  2     byte offset of the load
//     funct3_i   in  3     load size/sign (LB/LH/LW/LBU/LHU)
//     value_o    out XLEN  extracted, extended value
//     fault_o    out 1     misaligned access or illegal funct3
module load_align_ext
  import mem_wb_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     data_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] value_o,
  output logic            fault_o
);

  logic [31:0] shifted;

  // Move the addressed byte lane down to bit 0.
  assign shifted = data_i >> {addr_lo_i, 3'b000};

  always_comb begin
    value_o = '0;
    fault_o = 1'b0;
    case (funct3_i)
      F3_LB:  value_o = XLEN'($signed(shifted[7:0]));
      F3_LBU: value_o = XLEN'(shifted[7:0]);
      F3_LH: begin
        value_o = XLEN'($signed(shifted[15:0]));
        fault_o = addr_lo_i[0];
      end
      F3_LHU: begin
        value_o = XLEN'(shifted[15:0]);
        fault_o = addr_lo_i[0];
      end
      F3_LW: begin
        value_o = XLEN'($signed(shifted));
        fault_o = (addr_lo_i != 2'd0);
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_lsu_stage.sv
// Module mem_wb_lsu_stage
//   Memory/writeback stage between execute and the register file. Accepts
//   one instruction per cycle for ALU/PC writebacks, waits (with timeout)
//   for a load response on MEM ops, aligns/extends load data, reports
//   errors and keeps a short history of retired writes.
//   Ports:
//     clk, reset (async, active-low)
//     in_valid/in_ready, in_wb_op, in_funct3, in_rd, in_pc,
//     in_alu_result, in_addr_lo                 : instruction from execute
//     mem_rsp_valid, mem_rsp_data, mem_rsp_err  : load response
//     regs_write_out, regs_wr_id_out, regs_data_out : register-file write port
//     err_out   : one-cycle error pulse
//     busy_out  : waiting for a load response
//     hist_out  : HIST_DEPTH x {valid, rd}, entry 0 newest (lowest bits)
//   Optional: define MEMWB_BYPASS_EN to add byp_valid_out / byp_rd_out /
//   byp_data_out, the write about to be registered, for execute forwarding.
module mem_wb_lsu_stage
  import mem_wb_lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REGW       = 8,
  parameter int HIST_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_wb_op,
  input  logic [2:0]                   in_funct3,
  input  logic [REGW-1:0]              in_rd,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [XLEN-1:0]              in_alu_result,
  input  logic [1:0]                   in_addr_lo,
  input  logic                         mem_rsp_valid,
  input  logic [31:0]                  mem_rsp_data,
  input  logic                         mem_rsp_err,
  output logic                         regs_write_out,
  output logic [REGW-1:0]              regs_wr_id_out,
  output logic [XLEN-1:0]              regs_data_out,
  output logic                         err_out,
  output logic                         busy_out,
  output logic [HIST_DEPTH*(REGW+1)-1:0] hist_out
`ifdef MEMWB_BYPASS_EN
  ,
  output logic                         byp_valid_out,
  output logic [REGW-1:0]              byp_rd_out,
  output logic [XLEN-1:0]              byp_data_out
`endif
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int HW    = REGW + 1;

  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REGW-1:0]  rd_q, rd_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic             wr_q, wr_d, wr_strobe;
  logic [REGW-1:0]  wr_id_q, wr_id_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             err_q, err_d;
  logic [XLEN-1:0]  ld_value;
  logic             ld_fault;
  logic [HW-1:0]    hist_q [HIST_DEPTH];

  load_align_ext #(.XLEN(XLEN)) u_align (
    .data_i    (mem_rsp_data),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .value_o   (ld_value),
    .fault_o   (ld_fault)
  );

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    wr_strobe = 1'b0;
    wr_id_d   = '0;
    data_d    = '0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // A response with nothing outstanding is a protocol error.
        if (mem_rsp_valid) err_d = 1'b1;
        if (in_valid) begin
          case (in_wb_op)
            ALU: begin
              wr_strobe = 1'b1;
              wr_id_d   = in_rd;
              data_d    = in_alu_result;
            end
            PC2: begin
              wr_strobe = 1'b1;
              wr_id_d   = in_rd;
              data_d    = in_pc + XLEN'(2);
            end
            PC4: begin
              wr_strobe = 1'b1;
              wr_id_d   = in_rd;
              data_d    = in_pc + XLEN'(4);
            end
            MEM: begin
              state_d   = WAIT_MEM;
              cnt_d     = '0;
              rd_d      = in_rd;
              funct3_d  = in_funct3;
              addr_lo_d = in_addr_lo;
            end
            default: wr_id_d = in_rd;  // WNONE and unused codes retire without a write
          endcase
        end
      end
      WAIT_MEM: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          wr_id_d = rd_q;
          if (mem_rsp_err || ld_fault) begin
            err_d = 1'b1;
          end else begin
            wr_strobe = 1'b1;
            data_d    = ld_value;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          wr_id_d = rd_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // x0 is never written, but its data is still presented.
  assign wr_d = wr_strobe & (wr_id_d != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      wr_q      <= 1'b0;
      wr_id_q   <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      wr_q      <= wr_d;
      wr_id_q   <= wr_id_d;
      data_q    <= data_d;
      err_q     <= err_d;
      for (int i = HIST_DEPTH - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
      hist_q[0] <= {wr_d, wr_id_d};
    end
  end

  assign regs_write_out = wr_q;
  assign regs_wr_id_out = wr_id_q;
  assign regs_data_out  = data_q;
  assign err_out        = err_q;
  assign busy_out       = (state_q == WAIT_MEM);

  for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
    assign hist_out[gi*HW +: HW] = hist_q[gi];
  end

`ifdef MEMWB_BYPASS_EN
  assign byp_valid_out = wr_d;
  assign byp_rd_out    = wr_id_d;
  assign byp_data_out  = data_d;
`endif

endmodule

// File: tb/tb_mem_wb_lsu_stage.sv
module tb_mem_wb_lsu_stage;
  localparam int XLEN = 32;
  localparam int REGW = 8;
  localparam int HD   = 4;
  localparam int TO   = 15;
  localparam int HW   = REGW + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_wb_op;
  logic [2:0]        in_funct3;
  logic [REGW-1:0]   in_rd;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_alu_result;
  logic [1:0]        in_addr_lo;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic              mem_rsp_err;
  logic              regs_write_out;
  logic [REGW-1:0]   regs_wr_id_out;
  logic [XLEN-1:0]   regs_data_out;
  logic              err_out;
  logic              busy_out;
  logic [HD*HW-1:0]  hist_out;

  int errors = 0;
  int checks = 0;

  mem_wb_lsu_stage #(.XLEN(XLEN), .REGW(REGW), .HIST_DEPTH(HD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wb_op(in_wb_op), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_pc(in_pc), .in_alu_result(in_alu_result), .in_addr_lo(in_addr_lo),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .regs_write_out(regs_write_out), .regs_wr_id_out(regs_wr_id_out), .regs_data_out(regs_data_out),
    .err_out(err_out), .busy_out(busy_out), .hist_out(hist_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [HW-1:0] hent(input int i);
    return hist_out[i*HW +: HW];
  endfunction

  // Reference load extraction from the size/sign rules; returns 0 on a fault.
  function automatic bit ref_load(input logic [31:0] d, input int alo, input int f3,
                                  output logic [31:0] v);
    longint b, h;
    b = longint'((d >> (alo * 8)) & 32'hFF);
    h = longint'((d >> (alo * 8)) & 32'hFFFF);
    v = '0;
    case (f3)
      0: v = 32'((b >= 128) ? b - 256 : b);
      4: v = 32'(b);
      1: begin if (alo % 2 != 0) return 0; v = 32'((h >= 32768) ? h - 65536 : h); end
      5: begin if (alo % 2 != 0) return 0; v = 32'(h); end
      2: begin if (alo != 0) return 0; v = d; end
      default: return 0;
    endcase
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid = 0; in_wb_op = 0; in_funct3 = 0; in_rd = 0; in_pc = 0;
    in_alu_result = 0; in_addr_lo = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
  endtask

  task automatic issue(input int op, input int f3, input int rd, input logic [31:0] pc,
                       input logic [31:0] alu, input int alo);
    in_valid = 1; in_wb_op = 3'(op); in_funct3 = 3'(f3); in_rd = REGW'(rd);
    in_pc = pc; in_alu_result = alu; in_addr_lo = 2'(alo);
  endtask

  task automatic test_reset();
    clr_in();
    #1 reset = 0;
    #1;
    $display("txn reset asserted");
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (regs_write_out !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", regs_write_out); end
    checks++; if (regs_data_out !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", regs_data_out); end
    checks++; if (err_out !== 1'b0 || busy_out !== 1'b0) begin errors++; $display("FAIL reset_err_busy got=%b%b exp=00", err_out, busy_out); end
    checks++; if (hist_out !== '0) begin errors++; $display("FAIL reset_hist got=%h exp=0", hist_out); end
    #2 reset = 1;
    tick();
  endtask

  task automatic test_alu();
    issue(1, 0, 5, 32'h0, 32'h1234, 0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_ready_pre got=%b exp=1", in_ready); end
    tick(); clr_in();
    $display("txn alu rd=5 data=%h wr=%b", regs_data_out, regs_write_out);
    checks++; if (regs_write_out !== 1'b1) begin errors++; $display("FAIL alu_wr got=%b exp=1", regs_write_out); end
    checks++; if (regs_wr_id_out !== 8'd5) begin errors++; $display("FAIL alu_id got=%0d exp=5", regs_wr_id_out); end
    checks++; if (regs_data_out !== 32'h1234) begin errors++; $display("FAIL alu_data got=%h exp=1234", regs_data_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got=%b exp=1", in_ready); end
    checks++; if (hent(0) !== {1'b1, 8'd5}) begin errors++; $display("FAIL alu_hist0 got=%h exp=105", hent(0)); end
    tick();
    checks++; if (regs_write_out !== 1'b0) begin errors++; $display("FAIL alu_pulse got=%b exp=0", regs_write_out); end
  endtask

  task automatic test_load_lb();
    issue(2, 0, 7, 32'h0, 32'h0, 2);
    tick(); clr_in();
    checks++; if (busy_out !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL lb_wait got busy=%b ready=%b exp busy=1 ready=0", busy_out, in_ready); end
    tick(); tick();
    mem_rsp_valid = 1; mem_rsp_data = 32'h0080_0000;
    checks++; if (regs_write_out !== 1'b0) begin errors++; $display("FAIL lb_early got=%b exp=0", regs_write_out); end
    tick(); clr_in();
    $display("txn load lb rd=7 data=%h wr=%b", regs_data_out, regs_write_out);
    checks++; if (regs_write_out !== 1'b1 || regs_wr_id_out !== 8'd7) begin errors++; $display("FAIL lb_wr got wr=%b id=%0d exp wr=1 id=7", regs_write_out, regs_wr_id_out); end
    checks++; if (regs_data_out !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", regs_data_out); end
    checks++; if (err_out !== 1'b0 || in_ready !== 1'b1 || busy_out !== 1'b0) begin errors++; $display("FAIL lb_state got err=%b ready=%b busy=%b exp 0 1 0", err_out, in_ready, busy_out); end
  endtask

  task automatic test_misaligned();
    issue(2, 5, 3, 32'h0, 32'h0, 1);
    tick(); clr_in();
    mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD_BEEF;
    tick(); clr_in();
    $display("txn load lhu misaligned err=%b wr=%b", err_out, regs_write_out);
    checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL mis_err got=%b exp=1", err_out); end
    checks++; if (regs_write_out !== 1'b0) begin errors++; $display("FAIL mis_wr got=%b exp=0", regs_write_out); end
    checks++; if (in_ready !== 1'b1 || busy_out !== 1'b0) begin errors++; $display("FAIL mis_idle got ready=%b busy=%b exp 1 0", in_ready, busy_out); end
    tick();
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL mis_pulse got=%b exp=0", err_out); end
  endtask

  task automatic test_timeout();
    issue(2, 2, 9, 32'h0, 32'h0, 0);
    tick(); clr_in();
    for (int i = 1; i < TO; i++) begin
      tick();
      checks++; if (busy_out !== 1'b1 || err_out !== 1'b0) begin errors++; $display("FAIL to_wait%0d got busy=%b err=%b exp 1 0", i, busy_out, err_out); end
    end
    tick();
    $display("txn timeout err=%b busy=%b", err_out, busy_out);
    checks++; if (err_out !== 1'b1 || busy_out !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL to_abort got err=%b busy=%b ready=%b exp 1 0 1", err_out, busy_out, in_ready); end
    mem_rsp_valid = 1; mem_rsp_data = 32'h1111_2222;
    tick(); clr_in();
    checks++; if (regs_write_out !== 1'b0) begin errors++; $display("FAIL to_stray_wr got=%b exp=0", regs_write_out); end
    tick();
  endtask

  task automatic test_rd_zero();
    issue(4, 0, 0, 32'h100, 32'h0, 0);
    tick();
    issue(3, 0, 4, 32'h200, 32'h0, 0);
    $display("txn pc4 rd=0 data=%h wr=%b", regs_data_out, regs_write_out);
    checks++; if (regs_write_out !== 1'b0) begin errors++; $display("FAIL rd0_wr got=%b exp=0", regs_write_out); end
    checks++; if (regs_data_out !== 32'h104) begin errors++; $display("FAIL rd0_data got=%h exp=104", regs_data_out); end
    checks++; if (hent(0) !== {1'b0, 8'd0}) begin errors++; $display("FAIL rd0_hist got=%h exp=000", hent(0)); end
    tick(); clr_in();
    $display("txn pc2 rd=4 data=%h wr=%b", regs_data_out, regs_write_out);
    checks++; if (regs_write_out !== 1'b1 || regs_data_out !== 32'h202) begin errors++; $display("FAIL pc2 got wr=%b data=%h exp 1 202", regs_write_out, regs_data_out); end
  endtask

  task automatic test_reset_mid_wait();
    issue(2, 2, 11, 32'h0, 32'h0, 0);
    tick(); clr_in();
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL rst_busy_pre got=%b exp=1", busy_out); end
    #2 reset = 0;
    #1;
    $display("txn reset during wait busy=%b ready=%b", busy_out, in_ready);
    checks++; if (busy_out !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_async got busy=%b ready=%b exp 0 1", busy_out, in_ready); end
    checks++; if (hist_out !== '0 || regs_data_out !== '0 || regs_write_out !== 1'b0) begin errors++; $display("FAIL rst_outs got hist=%h data=%h wr=%b exp 0", hist_out, regs_data_out, regs_write_out); end
    #1 reset = 1;
    mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678;
    tick(); clr_in();
    checks++; if (regs_write_out !== 1'b0) begin errors++; $display("FAIL rst_stray_wr got=%b exp=0", regs_write_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] rds [4];
    for (int k = 0; k < 4; k++) begin
      rds[k] = 8'(8'h10 + k);
      issue(1, 0, int'(rds[k]), 32'h0, 32'h100 + k, 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%b exp=1", k, in_ready); end
      tick();
      $display("txn b2b rd=%0d data=%h wr=%b", regs_wr_id_out, regs_data_out, regs_write_out);
      checks++; if (regs_write_out !== 1'b1 || regs_wr_id_out !== rds[k] || regs_data_out !== 32'h100 + k) begin
        errors++; $display("FAIL b2b_wr%0d got wr=%b id=%0d data=%h exp 1 %0d %h", k, regs_write_out, regs_wr_id_out, regs_data_out, rds[k], 32'h100 + k);
      end
    end
    clr_in();
    for (int i = 0; i < 4; i++) begin
      checks++; if (hent(i) !== {1'b1, rds[3-i]}) begin errors++; $display("FAIL b2b_hist%0d got=%h exp=%h", i, hent(i), {1'b1, rds[3-i]}); end
    end
    tick();
  endtask

  task automatic test_random();
    bit              m_wait = 0;
    int              m_cnt = 0;
    logic [7:0]      m_rd = 0;
    int              m_f3 = 0, m_alo = 0;
    logic [HW-1:0]   mh [HD];
    bit              e_wr, e_err, e_done;
    logic [7:0]      e_id;
    logic [31:0]     e_data, v;
    int              rsp_div;
    reset = 0; #1 reset = 1;
    for (int i = 0; i < HD; i++) mh[i] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      clr_in();
      rsp_div = (cyc < 400) ? 3 : 24;
      in_valid      = ($urandom_range(0, 3) != 0);
      in_wb_op      = 3'($urandom_range(0, 4));
      in_funct3     = 3'($urandom_range(0, 7));
      in_rd         = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      in_pc         = $urandom;
      in_alu_result = $urandom;
      in_addr_lo    = 2'($urandom_range(0, 3));
      mem_rsp_valid = ($urandom_range(0, rsp_div - 1) == 0);
      mem_rsp_data  = $urandom;
      mem_rsp_err   = ($urandom_range(0, 9) == 0);
      e_wr = 0; e_err = 0; e_done = 0; e_id = 0; e_data = 0;
      if (!m_wait) begin
        if (mem_rsp_valid) e_err = 1;
        if (in_valid) begin
          e_id = in_rd;
          case (int'(in_wb_op))
            1: begin e_done = 1; e_data = in_alu_result; end
            3: begin e_done = 1; e_data = in_pc + 32'd2; end
            4: begin e_done = 1; e_data = in_pc + 32'd4; end
            2: begin m_wait = 1; m_cnt = 0; m_rd = in_rd; m_f3 = int'(in_funct3); m_alo = int'(in_addr_lo); e_id = 0; end
            default: ;
          endcase
        end
      end else if (mem_rsp_valid) begin
        m_wait = 0; e_id = m_rd;
        if (mem_rsp_err || !ref_load(mem_rsp_data, m_alo, m_f3, v)) e_err = 1;
        else begin e_done = 1; e_data = v; end
      end else begin
        m_cnt++;
        if (m_cnt == TO) begin m_wait = 0; e_err = 1; e_id = m_rd; end
      end
      e_wr = e_done && (e_id != 0);
      for (int i = HD - 1; i > 0; i--) mh[i] = mh[i-1];
      mh[0] = {e_wr, e_id};
      tick();
      if (e_done || e_err) $display("txn rnd cyc=%0d rd=%0d wr=%b err=%b data=%h", cyc, e_id, e_wr, e_err, e_data);
      checks++; if (regs_write_out !== e_wr) begin errors++; $display("FAIL rnd_wr cyc=%0d got=%b exp=%b", cyc, regs_write_out, e_wr); end
      checks++; if (err_out !== e_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err_out, e_err); end
      checks++; if (busy_out !== m_wait || in_ready !== !m_wait) begin errors++; $display("FAIL rnd_state cyc=%0d got busy=%b ready=%b exp busy=%b", cyc, busy_out, in_ready, m_wait); end
      if (e_done) begin
        checks++; if (regs_wr_id_out !== e_id || regs_data_out !== e_data) begin errors++; $display("FAIL rnd_data cyc=%0d got id=%0d data=%h exp id=%0d data=%h", cyc, regs_wr_id_out, regs_data_out, e_id, e_data); end
      end
      for (int i = 0; i < HD; i++) begin
        checks++; if (hent(i)[REGW] !== mh[i][REGW]) begin errors++; $display("FAIL rnd_hist_v%0d cyc=%0d got=%b exp=%b", i, cyc, hent(i)[REGW], mh[i][REGW]); end
        if (mh[i][REGW]) begin
          checks++; if (hent(i) !== mh[i]) begin errors++; $display("FAIL rnd_hist_rd%0d cyc=%0d got=%h exp=%h", i, cyc, hent(i), mh[i]); end
        end
      end
    end
    clr_in();
  endtask

  initial begin
    clr_in();
    test_reset();
    test_alu();
    test_load_lb();
    test_misaligned();
    test_timeout();
    test_rd_zero();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
